// File: rtl/exm_stage.sv
// Execute/memory stage: ALU, {C,N,Z} flags, branch resolve, stack pointer and a
// two-cycle push/pop-PC sequencer. Optional stack bounds check: EXM_STACK_CHECK_EN.
module exm_stage (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_alu_function,
  input  logic [2:0]  i_branch_selector,
  input  logic        i_write_back,
  input  logic        i_change_carry,
  input  logic        i_carry_value,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_stack_operation,
  input  logic        i_stack_function,
  input  logic        i_branch_operation,
  input  logic        i_push_pc,
  input  logic        i_pop_pc,
  input  logic        i_imm,
  input  logic [15:0] i_data1,
  input  logic [15:0] i_data2,
  input  logic [15:0] i_sh_amount,
  input  logic [2:0]  i_rd,
  input  logic [31:0] i_pc,
  output logic [15:0] o_alu_result,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_write_back,
  output logic [2:0]  o_rd,
  output logic [2:0]  o_flags,
  output logic [15:0] o_sp,
  output logic        o_branch_taken,
  output logic [15:0] o_branch_target,
  output logic        o_stall,
  output logic        o_dbg_state
`ifdef EXM_STACK_CHECK_EN
  ,
  output logic        o_stack_fault
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_PC2 = 1'b1} state_t;

  localparam logic [15:0] SP_RESET = 16'h07FF;

  state_t      state_q, state_d;
  logic        pc2_push_q, pc2_push_d;
  logic [15:0] sp_q, sp_d;
  logic        c_q, n_q, z_q;
  logic        c_d, n_d, z_d;

  logic [15:0] op_b;
  logic [3:0]  shamt;
  logic [16:0] sum17, diff17;
  logic [4:0]  shl_idx;
  logic [3:0]  shr_idx;
  logic [15:0] alu_res;
  logic        carry_upd, carry_val;

  logic        acc_push, acc_pop, fault;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_read, mem_write, write_back, stall, taken;

  // ALU
  always_comb begin
    op_b      = i_imm ? i_sh_amount : i_data2;
    shamt     = i_sh_amount[3:0];
    sum17     = {1'b0, i_data1} + {1'b0, op_b};
    diff17    = {1'b0, i_data1} - {1'b0, op_b};
    shl_idx   = 5'd16 - {1'b0, shamt};
    shr_idx   = shamt - 4'd1;
    alu_res   = 16'h0000;
    carry_upd = 1'b0;
    carry_val = c_q;
    case (i_alu_function)
      3'b000: alu_res = op_b;
      3'b001: begin alu_res = sum17[15:0];  carry_upd = 1'b1; carry_val = sum17[16];  end
      3'b010: begin alu_res = diff17[15:0]; carry_upd = 1'b1; carry_val = diff17[16]; end
      3'b011: alu_res = i_data1 & op_b;
      3'b100: alu_res = i_data1 | op_b;
      3'b101: alu_res = ~i_data1;
      3'b110: begin
        alu_res   = i_data1 << shamt;
        carry_upd = (shamt != 4'd0);
        carry_val = i_data1[shl_idx[3:0]];
      end
      default: begin
        alu_res   = i_data1 >> shamt;
        carry_upd = (shamt != 4'd0);
        carry_val = i_data1[shr_idx];
      end
    endcase
  end

  // Sequencer, stack, flags and branch decision
  always_comb begin
    state_d    = state_q;
    pc2_push_d = pc2_push_q;
    sp_d       = sp_q;
    c_d        = c_q;
    n_d        = n_q;
    z_d        = z_q;
    acc_push   = 1'b0;
    acc_pop    = 1'b0;
    fault      = 1'b0;
    mem_addr   = alu_res;
    mem_wdata  = i_data2;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_back = 1'b0;
    stall      = 1'b0;
    taken      = 1'b0;

    if (state_q == S_IDLE) begin
      if (i_push_pc || i_pop_pc) begin
        state_d    = S_PC2;
        pc2_push_d = i_push_pc;
        stall      = 1'b1;
        acc_push   = i_push_pc;
        acc_pop    = !i_push_pc;
        mem_wdata  = i_pc[31:16];
      end else if (i_stack_operation) begin
        acc_push   = i_stack_function;
        acc_pop    = !i_stack_function;
        mem_wdata  = i_data1;
        write_back = i_write_back;
      end else begin
        mem_read   = i_mem_read;
        mem_write  = i_mem_write;
        write_back = i_write_back;
        if (i_write_back) begin
          z_d = (alu_res == 16'h0000);
          n_d = alu_res[15];
          if (carry_upd) c_d = carry_val;
        end
        if (i_change_carry) c_d = i_carry_value;
        // Conditional branches consume the flag they tested.
        if (i_branch_operation) begin
          case (i_branch_selector)
            3'b000:  begin taken = z_q; if (z_q) z_d = 1'b0; end
            3'b001:  begin taken = n_q; if (n_q) n_d = 1'b0; end
            3'b010:  begin taken = c_q; if (c_q) c_d = 1'b0; end
            3'b011:  taken = 1'b1;
            default: taken = 1'b0;
          endcase
        end
      end
    end else begin
      state_d   = S_IDLE;
      acc_push  = pc2_push_q;
      acc_pop   = !pc2_push_q;
      mem_wdata = i_pc[15:0];
    end

`ifdef EXM_STACK_CHECK_EN
    fault = (acc_push && (sp_q == 16'h0000)) || (acc_pop && (sp_q == SP_RESET));
`endif

    // Push is post-decrement, pop is pre-increment; a faulting access is dropped.
    if (acc_push) begin
      mem_addr = sp_q;
      if (!fault) begin
        mem_write = 1'b1;
        sp_d      = sp_q - 16'd1;
      end
    end else if (acc_pop) begin
      mem_addr = sp_q + 16'd1;
      if (!fault) begin
        mem_read = 1'b1;
        sp_d     = sp_q + 16'd1;
      end
    end

    if (!i_reset) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      write_back = 1'b0;
      stall      = 1'b0;
      taken      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      pc2_push_q <= 1'b0;
      sp_q       <= SP_RESET;
      c_q        <= 1'b0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc2_push_q <= pc2_push_d;
      sp_q       <= sp_d;
      c_q        <= c_d;
      n_q        <= n_d;
      z_q        <= z_d;
    end
  end

`ifdef EXM_STACK_CHECK_EN
  logic fault_q;
  always_ff @(posedge i_clk) begin
    if (!i_reset)  fault_q <= 1'b0;
    else if (fault) fault_q <= 1'b1;
  end
  assign o_stack_fault = fault_q;
`endif

  assign o_alu_result    = alu_res;
  assign o_mem_addr      = mem_addr;
  assign o_mem_wdata     = mem_wdata;
  assign o_mem_read      = mem_read;
  assign o_mem_write     = mem_write;
  assign o_write_back    = write_back;
  assign o_rd            = i_rd;
  assign o_flags         = {c_q, n_q, z_q};
  assign o_sp            = sp_q;
  assign o_branch_taken  = taken;
  assign o_branch_target = i_data1;
  assign o_stall         = o_stall_int();
  assign o_dbg_state     = state_q;

  function automatic logic o_stall_int();
    return stall;
  endfunction

endmodule

// File: tb/tb_exm_stage.sv
// Scoreboard bench for exm_stage: driver pushes {cycle, field, value} expectations,
// a negedge monitor pops and compares the ones due in the current cycle.
module tb_exm_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [2:0]  i_alu_function, i_branch_selector;
  logic        i_write_back, i_change_carry, i_carry_value, i_mem_read, i_mem_write;
  logic        i_stack_operation, i_stack_function, i_branch_operation;
  logic        i_push_pc, i_pop_pc, i_imm;
  logic [15:0] i_data1, i_data2, i_sh_amount;
  logic [2:0]  i_rd;
  logic [31:0] i_pc;
  logic [15:0] o_alu_result, o_mem_addr, o_mem_wdata, o_sp, o_branch_target;
  logic        o_mem_read, o_mem_write, o_write_back, o_branch_taken, o_stall, o_dbg_state;
  logic [2:0]  o_rd, o_flags;
`ifdef EXM_STACK_CHECK_EN
  logic        o_stack_fault;
`endif

  exm_stage dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_alu_function(i_alu_function), .i_branch_selector(i_branch_selector),
    .i_write_back(i_write_back), .i_change_carry(i_change_carry),
    .i_carry_value(i_carry_value), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_stack_operation(i_stack_operation), .i_stack_function(i_stack_function),
    .i_branch_operation(i_branch_operation), .i_push_pc(i_push_pc), .i_pop_pc(i_pop_pc),
    .i_imm(i_imm), .i_data1(i_data1), .i_data2(i_data2), .i_sh_amount(i_sh_amount),
    .i_rd(i_rd), .i_pc(i_pc),
    .o_alu_result(o_alu_result), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_write_back(o_write_back),
    .o_rd(o_rd), .o_flags(o_flags), .o_sp(o_sp), .o_branch_taken(o_branch_taken),
    .o_branch_target(o_branch_target), .o_stall(o_stall), .o_dbg_state(o_dbg_state)
`ifdef EXM_STACK_CHECK_EN
    , .o_stack_fault(o_stack_fault)
`endif
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  logic [15:0] cyc = 16'd0;
  always @(posedge i_clk) cyc <= cyc + 16'd1;

  localparam int F_ALU = 0, F_ADDR = 1, F_WDATA = 2, F_RD_EN = 3, F_WR_EN = 4,
                 F_WB = 5, F_RD = 6, F_FLAGS = 7, F_SP = 8, F_TAKEN = 9,
                 F_TARGET = 10, F_STALL = 11, F_FAULT = 12, F_STATE = 13;

  logic [35:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] act(input logic [3:0] f);
    case (f)
      4'd0:  return o_alu_result;
      4'd1:  return o_mem_addr;
      4'd2:  return o_mem_wdata;
      4'd3:  return {15'd0, o_mem_read};
      4'd4:  return {15'd0, o_mem_write};
      4'd5:  return {15'd0, o_write_back};
      4'd6:  return {13'd0, o_rd};
      4'd7:  return {13'd0, o_flags};
      4'd8:  return o_sp;
      4'd9:  return {15'd0, o_branch_taken};
      4'd10: return o_branch_target;
      4'd11: return {15'd0, o_stall};
`ifdef EXM_STACK_CHECK_EN
      4'd12: return {15'd0, o_stack_fault};
`endif
      4'd13: return {15'd0, o_dbg_state};
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic string fname(input logic [3:0] f);
    case (f)
      4'd0: return "alu_result"; 4'd1: return "mem_addr";  4'd2: return "mem_wdata";
      4'd3: return "mem_read";   4'd4: return "mem_write"; 4'd5: return "write_back";
      4'd6: return "rd";         4'd7: return "flags";     4'd8: return "sp";
      4'd9: return "branch_taken"; 4'd10: return "branch_target"; 4'd11: return "stall";
      4'd12: return "stack_fault"; default: return "dbg_state";
    endcase
  endfunction

  // Driver tasks
  task automatic expect_f(input int f, input logic [15:0] v);
    exp_q.push_back({cyc, f[3:0], v});
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
    i_reset = 1'b1; i_alu_function = 3'b000; i_branch_selector = 3'b000;
    i_write_back = 1'b0; i_change_carry = 1'b0; i_carry_value = 1'b0;
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_stack_operation = 1'b0;
    i_stack_function = 1'b0; i_branch_operation = 1'b0; i_push_pc = 1'b0;
    i_pop_pc = 1'b0; i_imm = 1'b0; i_data1 = 16'h0; i_data2 = 16'h0;
    i_sh_amount = 16'h0; i_rd = 3'd0; i_pc = 32'h0;
  endtask

  task automatic alu_op(input logic [2:0] fn, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] sh, input logic wb);
    i_alu_function = fn; i_data1 = a; i_data2 = b; i_sh_amount = sh; i_write_back = wb;
  endtask

  // Scoreboard monitor
  always @(negedge i_clk) begin
    while (exp_q.size() > 0 && exp_q[0][35:20] <= cyc) begin
      logic [35:0] e;
      logic [15:0] a;
      e = exp_q.pop_front();
      a = act(e[19:16]);
      checks++;
      if (e[35:20] != cyc || a !== e[15:0]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", fname(e[19:16]), e[35:20], a, e[15:0]);
      end
    end
  end

  initial begin
    i_reset = 1'b0; i_alu_function = 3'b0; i_branch_selector = 3'b0; i_write_back = 1'b0;
    i_change_carry = 1'b0; i_carry_value = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_stack_operation = 1'b0; i_stack_function = 1'b0; i_branch_operation = 1'b0;
    i_push_pc = 1'b0; i_pop_pc = 1'b0; i_imm = 1'b0; i_data1 = 16'h0; i_data2 = 16'h0;
    i_sh_amount = 16'h0; i_rd = 3'd0; i_pc = 32'h0;

    // Reset: strobes masked even with a push_pc request present
    next_cycle(); i_reset = 1'b0; i_push_pc = 1'b1; i_write_back = 1'b1;
    expect_f(F_STALL, 0); expect_f(F_WR_EN, 0); expect_f(F_WB, 0);
    next_cycle(); i_reset = 1'b0;
    expect_f(F_SP, 16'h07FF); expect_f(F_FLAGS, 3'b000); expect_f(F_STATE, 0);
    expect_f(F_TAKEN, 0); expect_f(F_RD_EN, 0);

    // ADD 8000+8000 -> 0, then C=1 N=0 Z=1
    next_cycle(); alu_op(3'b001, 16'h8000, 16'h8000, 16'h0, 1'b1); i_rd = 3'd3;
    expect_f(F_ALU, 16'h0000); expect_f(F_WB, 1); expect_f(F_RD, 3); expect_f(F_FLAGS, 3'b000);
    expect_f(F_WR_EN, 0); expect_f(F_RD_EN, 0);
    next_cycle(); alu_op(3'b000, 16'h0, 16'h5A5A, 16'h0, 1'b0);
    expect_f(F_FLAGS, 3'b101); expect_f(F_ALU, 16'h5A5A); expect_f(F_WB, 0);

    // SUB 5-7 then JN; N consumed by the taken branch
    next_cycle(); alu_op(3'b010, 16'd5, 16'd7, 16'h0, 1'b1);
    expect_f(F_ALU, 16'hFFFE);
    next_cycle(); i_branch_operation = 1'b1; i_branch_selector = 3'b001; i_data1 = 16'h1234;
    expect_f(F_FLAGS, 3'b110); expect_f(F_TAKEN, 1); expect_f(F_TARGET, 16'h1234);
    next_cycle(); i_branch_operation = 1'b1; i_branch_selector = 3'b000; i_data1 = 16'h4321;
    expect_f(F_FLAGS, 3'b100); expect_f(F_TAKEN, 0);
    next_cycle(); i_branch_operation = 1'b1; i_branch_selector = 3'b011; i_data1 = 16'h00AA;
    expect_f(F_TAKEN, 1); expect_f(F_TARGET, 16'h00AA);
    next_cycle(); i_branch_operation = 1'b1; i_branch_selector = 3'b110;
    expect_f(F_TAKEN, 0); expect_f(F_FLAGS, 3'b100);

    // Immediate operand B, then SHR carry, SETC, SHL by 0 keeps C
    next_cycle(); alu_op(3'b001, 16'd10, 16'd99, 16'd5, 1'b1); i_imm = 1'b1;
    expect_f(F_ALU, 16'h000F);
    next_cycle(); alu_op(3'b111, 16'h0002, 16'h0, 16'd1, 1'b1);
    expect_f(F_FLAGS, 3'b000); expect_f(F_ALU, 16'h0001);
    next_cycle(); i_change_carry = 1'b1; i_carry_value = 1'b1;
    expect_f(F_FLAGS, 3'b000);
    next_cycle(); alu_op(3'b110, 16'h8001, 16'h0, 16'd0, 1'b1);
    expect_f(F_FLAGS, 3'b100); expect_f(F_ALU, 16'h8001);
    next_cycle(); alu_op(3'b101, 16'h00FF, 16'h0, 16'h0, 1'b0);
    expect_f(F_FLAGS, 3'b110); expect_f(F_ALU, 16'hFF00);
    next_cycle(); alu_op(3'b110, 16'h8001, 16'h0, 16'd1, 1'b1);
    expect_f(F_ALU, 16'h0002);
    next_cycle(); alu_op(3'b011, 16'hF0F0, 16'h3C3C, 16'h0, 1'b0);
    expect_f(F_FLAGS, 3'b100); expect_f(F_ALU, 16'h3030);

    // push_pc 0001_0020 from 07FF
    next_cycle(); i_push_pc = 1'b1; i_pc = 32'h0001_0020; i_alu_function = 3'b001;
    expect_f(F_STALL, 1); expect_f(F_WR_EN, 1); expect_f(F_RD_EN, 0);
    expect_f(F_ADDR, 16'h07FF); expect_f(F_WDATA, 16'h0001); expect_f(F_STATE, 0);
    next_cycle(); i_push_pc = 1'b1; i_pc = 32'h0001_0020;
    expect_f(F_STALL, 0); expect_f(F_WR_EN, 1); expect_f(F_ADDR, 16'h07FE);
    expect_f(F_WDATA, 16'h0020); expect_f(F_STATE, 1);
    next_cycle();
    expect_f(F_SP, 16'h07FD); expect_f(F_WR_EN, 0); expect_f(F_STALL, 0);

    // pop_pc from 07FD
    next_cycle(); i_pop_pc = 1'b1;
    expect_f(F_STALL, 1); expect_f(F_RD_EN, 1); expect_f(F_WR_EN, 0); expect_f(F_ADDR, 16'h07FE);
    next_cycle(); i_pop_pc = 1'b1;
    expect_f(F_STALL, 0); expect_f(F_RD_EN, 1); expect_f(F_ADDR, 16'h07FF); expect_f(F_SP, 16'h07FE);
    next_cycle();
    expect_f(F_SP, 16'h07FF); expect_f(F_RD_EN, 0);

    // Plain push/pop and a memory read
    next_cycle(); i_stack_operation = 1'b1; i_stack_function = 1'b1; i_data1 = 16'hABCD;
    expect_f(F_ADDR, 16'h07FF); expect_f(F_WR_EN, 1); expect_f(F_WDATA, 16'hABCD);
    next_cycle(); i_stack_operation = 1'b1; i_stack_function = 1'b0;
    expect_f(F_ADDR, 16'h07FF); expect_f(F_RD_EN, 1); expect_f(F_SP, 16'h07FE);
    next_cycle(); alu_op(3'b001, 16'h0100, 16'h0004, 16'h0, 1'b0); i_mem_read = 1'b1;
    expect_f(F_SP, 16'h07FF); expect_f(F_ADDR, 16'h0104); expect_f(F_RD_EN, 1);

    // Reset during PC2 abandons the sequence without a strobe
    next_cycle(); i_push_pc = 1'b1; i_pc = 32'hCAFE_BEEF;
    expect_f(F_STALL, 1); expect_f(F_WR_EN, 1);
    next_cycle(); i_reset = 1'b0; i_push_pc = 1'b1; i_pc = 32'hCAFE_BEEF;
    expect_f(F_STALL, 0); expect_f(F_WR_EN, 0); expect_f(F_RD_EN, 0);
    next_cycle();
    expect_f(F_SP, 16'h07FF); expect_f(F_STATE, 0); expect_f(F_STALL, 0);
    expect_f(F_WR_EN, 0); expect_f(F_FLAGS, 3'b000);

`ifdef EXM_STACK_CHECK_EN
    // Pop at the reset SP faults and is suppressed
    next_cycle(); i_stack_operation = 1'b1; i_stack_function = 1'b0;
    expect_f(F_RD_EN, 0); expect_f(F_FAULT, 0);
    next_cycle(); i_stack_operation = 1'b1; i_stack_function = 1'b1; i_data1 = 16'h1111;
    expect_f(F_FAULT, 1); expect_f(F_SP, 16'h07FF); expect_f(F_WR_EN, 1);
    next_cycle();
    expect_f(F_FAULT, 1); expect_f(F_SP, 16'h07FE);
`else
    // SP wraps modulo 2^16: walk down to 0000, push once more, pop back
    for (int k = 0; k < 2047; k++) begin
      next_cycle(); i_stack_operation = 1'b1; i_stack_function = 1'b1;
    end
    next_cycle(); i_stack_operation = 1'b1; i_stack_function = 1'b1;
    expect_f(F_SP, 16'h0000); expect_f(F_ADDR, 16'h0000); expect_f(F_WR_EN, 1);
    next_cycle(); i_stack_operation = 1'b1; i_stack_function = 1'b0;
    expect_f(F_SP, 16'hFFFF); expect_f(F_ADDR, 16'h0000); expect_f(F_RD_EN, 1);
    next_cycle();
    expect_f(F_SP, 16'h0000);
`endif

    next_cycle();
    @(negedge i_clk);
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("FAIL idle stall: got %b expected 0", o_stall);
    end
    checks++;
    if ({o_mem_read, o_mem_write} !== 2'b00) begin
      errors++;
      $display("FAIL idle strobes: got %b%b expected 00", o_mem_read, o_mem_write);
    end
    checks++;
    if (o_branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL idle branch_taken: got %b expected 0", o_branch_taken);
    end
    checks++;
    if (o_dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL idle dbg_state: got %b expected 0", o_dbg_state);
    end
    while (exp_q.size() > 0) begin
      logic [35:0] e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s cycle %0d: never checked, expected %h", fname(e[19:16]), e[35:20], e[15:0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
